// File: rtl/debug_pkg.sv
// Shared debug definitions: opcodes, response status layout and the
// timeout sentinel used by debug_readback and the debug controller.
package debug_pkg;

  localparam logic [7:0]  DBG_OP_READIMEM = 8'h04;
  localparam logic [7:0]  DBG_OP_READDMEM = 8'h06;

  // rsp_status bit positions
  localparam int ST_VALID   = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_DMEM    = 3;
  localparam int ST_SEQ_LSB = 4;
  localparam int ST_SEQ_W   = 4;

  localparam logic [31:0] RB_TIMEOUT_WORD = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    RB_IDLE,
    RB_REQ,
    RB_WAIT,
    RB_PUBLISH,
    RB_HOLD
  } rb_state_t;

  // Captured outcome of one read, written into the response registers.
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  status;
  } rb_rsp_t;

  function automatic logic is_read_op(input logic [7:0] op,
                                      input logic [7:0] op_imem,
                                      input logic [7:0] op_dmem);
    return (op == op_imem) || (op == op_dmem);
  endfunction

endpackage

// File: rtl/debug_readback_if.sv
// Bus bundle between the debug controller, the CPU memories and the TAP
// response side. slave = debug_readback view, master = everything around it.
interface debug_readback_if;
  logic        exec_valid;
  logic [7:0]  exec_op;
  logic [31:0] imem_addr;
  logic [31:0] dmem_addr;

  logic        cpu_imem_re;
  logic        cpu_dmem_re;
  logic [31:0] cpu_imem_addr;
  logic [31:0] cpu_dmem_addr;
  logic [31:0] cpu_imem_rdata;
  logic [31:0] cpu_dmem_rdata;
  logic        cpu_imem_rvalid;
  logic        cpu_dmem_rvalid;

  logic [31:0] rsp_data;
  logic [7:0]  rsp_status;
  logic        rsp_toggle;
  logic        rsp_ack;

  modport slave (
    input  exec_valid, exec_op, imem_addr, dmem_addr,
    input  cpu_imem_rdata, cpu_dmem_rdata, cpu_imem_rvalid, cpu_dmem_rvalid,
    input  rsp_ack,
    output cpu_imem_re, cpu_dmem_re, cpu_imem_addr, cpu_dmem_addr,
    output rsp_data, rsp_status, rsp_toggle
  );

  modport master (
    output exec_valid, exec_op, imem_addr, dmem_addr,
    output cpu_imem_rdata, cpu_dmem_rdata, cpu_imem_rvalid, cpu_dmem_rvalid,
    output rsp_ack,
    input  cpu_imem_re, cpu_dmem_re, cpu_imem_addr, cpu_dmem_addr,
    input  rsp_data, rsp_status, rsp_toggle
  );
endinterface

// File: rtl/debug_readback_timer.sv
// Loadable down-counter; expired is high during the last counted cycle so
// the owner can act on the same edge the count runs out.
module readback_timer #(
  parameter int W = 8
) (
  input  logic         cpu_clk,
  input  logic         cpu_rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn)                 cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (dec && (cnt != '0))   cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == W'(1));

endmodule

// File: rtl/debug_readback.sv
// Debug memory readback: issues one imem/dmem read per debug opcode, waits
// for data or timeout, and publishes the result to the TAP with a toggle handshake.
module debug_readback
  import debug_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [7:0] OP_READIMEM    = DBG_OP_READIMEM,
  parameter logic [7:0] OP_READDMEM    = DBG_OP_READDMEM
) (
  input logic             cpu_clk,
  input logic             cpu_rstn,
  debug_readback_if.slave bus
);

  rb_state_t state, state_nxt;

  logic    dmem_sel;
  logic    ovr_pend;
  logic    ovr_cur;
  logic    toggle_q;
  rb_rsp_t rsp_q, rsp_nxt;

  logic        rd_op;
  logic        rvalid_sel;
  logic [31:0] rdata_sel;
  logic        publish;
  logic        tmr_load, tmr_dec, tmr_expired;
  logic        imem_re, dmem_re;

  assign rd_op      = bus.exec_valid && is_read_op(bus.exec_op, OP_READIMEM, OP_READDMEM);
  assign rvalid_sel = dmem_sel ? bus.cpu_dmem_rvalid : bus.cpu_imem_rvalid;
  assign rdata_sel  = dmem_sel ? bus.cpu_dmem_rdata  : bus.cpu_imem_rdata;

  readback_timer #(.W(8)) u_timer (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .load     (tmr_load),
    .load_val (8'(TIMEOUT_CYCLES)),
    .dec      (tmr_dec),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_nxt = state;
    imem_re   = 1'b0;
    dmem_re   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    publish   = 1'b0;
    case (state)
      RB_IDLE: if (rd_op) state_nxt = RB_REQ;
      RB_REQ: begin
        imem_re   = !dmem_sel;
        dmem_re   = dmem_sel;
        tmr_load  = 1'b1;
        state_nxt = RB_WAIT;
      end
      RB_WAIT: begin
        tmr_dec = 1'b1;
        // data arriving on the expiry cycle still wins over the timeout
        if (rvalid_sel || tmr_expired) begin
          publish   = 1'b1;
          state_nxt = RB_PUBLISH;
        end
      end
      RB_PUBLISH: state_nxt = RB_HOLD;
      RB_HOLD:    if (bus.rsp_ack == toggle_q) state_nxt = RB_IDLE;
      default:    state_nxt = RB_IDLE;
    endcase
  end

  always_comb begin
    rsp_nxt                                   = rsp_q;
    rsp_nxt.data                              = rvalid_sel ? rdata_sel : RB_TIMEOUT_WORD;
    rsp_nxt.status                            = '0;
    rsp_nxt.status[ST_VALID]                  = rvalid_sel;
    rsp_nxt.status[ST_TIMEOUT]                = !rvalid_sel;
    rsp_nxt.status[ST_OVERRUN]                = ovr_cur;
    rsp_nxt.status[ST_DMEM]                   = dmem_sel;
    rsp_nxt.status[ST_SEQ_LSB +: ST_SEQ_W]    = rsp_q.status[ST_SEQ_LSB +: ST_SEQ_W] + 4'd1;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state    <= RB_IDLE;
      dmem_sel <= 1'b0;
      ovr_pend <= 1'b0;
      ovr_cur  <= 1'b0;
      toggle_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state <= state_nxt;
      if (rd_op) begin
        if (state == RB_IDLE) begin
          // a pending overrun is charged to the request accepted after it
          dmem_sel <= (bus.exec_op == OP_READDMEM);
          ovr_cur  <= ovr_pend;
          ovr_pend <= 1'b0;
        end else begin
          ovr_pend <= 1'b1;
        end
      end
      // response regs load on the edge into PUBLISH, so the toggle flips
      // the cycle after rvalid is sampled and stays put through HOLD
      if (publish) begin
        rsp_q    <= rsp_nxt;
        toggle_q <= ~toggle_q;
      end
    end
  end

  assign bus.cpu_imem_re   = imem_re;
  assign bus.cpu_dmem_re   = dmem_re;
  assign bus.cpu_imem_addr = bus.imem_addr;
  assign bus.cpu_dmem_addr = bus.dmem_addr;
  assign bus.rsp_data      = rsp_q.data;
  assign bus.rsp_status    = rsp_q.status;
  assign bus.rsp_toggle    = toggle_q;

endmodule

// File: tb/tb_debug_readback.sv
// Directed bench for debug_readback: vector table of reads plus hand-written
// sequences for ignored opcodes, reset during WAIT and sequence wrap.
module tb_debug_readback;

  logic cpu_clk  = 1'b0;
  logic cpu_rstn = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  debug_readback_if bus();

  debug_readback #(
    .TIMEOUT_CYCLES (16),
    .OP_READIMEM    (8'h04),
    .OP_READDMEM    (8'h06)
  ) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (bus.slave)
  );

  typedef struct {
    logic [7:0]  op;
    int          lat;      // cycles after re that rvalid is driven, 0 = never
    bit          wrong;    // drive the unselected memory's rvalid instead
    bit          hold_ovr; // issue a second DMEM read while in HOLD
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic [7:0]  exp_st;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;
  int ire_cnt = 0;
  int dre_cnt = 0;

  always @(posedge cpu_clk) begin
    if (bus.cpu_imem_re) ire_cnt <= ire_cnt + 1;
    if (bus.cpu_dmem_re) dre_cnt <= dre_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   ic0, dc0, flip, exp_flip;
    logic tog0, sel_d;
    sel_d    = (v.op == 8'h06);
    exp_flip = (v.lat == 0 || v.wrong) ? 17 : v.lat + 1;
    @(negedge cpu_clk);
    ic0  = ire_cnt;
    dc0  = dre_cnt;
    tog0 = bus.rsp_toggle;
    bus.imem_addr  = v.addr;
    bus.dmem_addr  = v.addr ^ 32'hFFFF_0000;
    bus.exec_op    = v.op;
    bus.exec_valid = 1'b1;
    @(negedge cpu_clk);
    bus.exec_valid = 1'b0;
    chk({tag, ".re"}, {30'b0, bus.cpu_imem_re, bus.cpu_dmem_re}, {30'b0, !sel_d, sel_d});
    chk({tag, ".addr"}, sel_d ? bus.cpu_dmem_addr : bus.cpu_imem_addr,
        sel_d ? (v.addr ^ 32'hFFFF_0000) : v.addr);
    flip = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge cpu_clk);
      bus.cpu_imem_rvalid = 1'b0;
      bus.cpu_dmem_rvalid = 1'b0;
      if (bus.rsp_toggle !== tog0) begin
        flip = k;
        break;
      end
      if (k == v.lat) begin
        bus.cpu_imem_rdata = v.rdata;
        bus.cpu_dmem_rdata = v.rdata;
        if (sel_d ^ v.wrong) bus.cpu_dmem_rvalid = 1'b1;
        else                 bus.cpu_imem_rvalid = 1'b1;
      end
    end
    chk({tag, ".lat"}, 32'(flip), 32'(exp_flip));
    chk({tag, ".data"}, bus.rsp_data, v.exp_data);
    chk({tag, ".status"}, {24'b0, bus.rsp_status}, {24'b0, v.exp_st});
    if (v.hold_ovr) begin
      @(negedge cpu_clk);
      bus.exec_op    = 8'h06;
      bus.exec_valid = 1'b1;
      @(negedge cpu_clk);
      bus.exec_valid = 1'b0;
      repeat (4) @(negedge cpu_clk);
      chk({tag, ".hold_toggle"}, {31'b0, bus.rsp_toggle}, {31'b0, ~tog0});
      chk({tag, ".hold_data"}, bus.rsp_data, v.exp_data);
    end
    bus.rsp_ack = bus.rsp_toggle;
    @(negedge cpu_clk);
    chk({tag, ".re_count"}, 32'((ire_cnt - ic0) * 16 + (dre_cnt - dc0)),
        sel_d ? 32'd1 : 32'd16);
  endtask

  vec_t vecs[8];
  vec_t w;
  logic [7:0] noops[3];
  int   ic0, dc0;
  logic tog0;

  initial begin
    vecs[0] = '{op:8'h04, lat:3,  wrong:0, hold_ovr:0, rdata:32'h12345678, addr:32'h0000_0100,
                exp_data:32'h12345678, exp_st:8'h11};
    vecs[1] = '{op:8'h06, lat:0,  wrong:0, hold_ovr:0, rdata:32'h0,        addr:32'h0000_0200,
                exp_data:32'hDEADBEEF, exp_st:8'h2A};
    vecs[2] = '{op:8'h06, lat:1,  wrong:0, hold_ovr:0, rdata:32'hCAFEF00D, addr:32'h0000_0204,
                exp_data:32'hCAFEF00D, exp_st:8'h39};
    vecs[3] = '{op:8'h04, lat:16, wrong:0, hold_ovr:0, rdata:32'hA5A5A5A5, addr:32'h0000_0104,
                exp_data:32'hA5A5A5A5, exp_st:8'h41};
    vecs[4] = '{op:8'h04, lat:5,  wrong:1, hold_ovr:0, rdata:32'h11112222, addr:32'h0000_0108,
                exp_data:32'hDEADBEEF, exp_st:8'h52};
    vecs[5] = '{op:8'h06, lat:2,  wrong:0, hold_ovr:1, rdata:32'h0BADF00D, addr:32'h0000_0300,
                exp_data:32'h0BADF00D, exp_st:8'h69};
    vecs[6] = '{op:8'h04, lat:1,  wrong:0, hold_ovr:0, rdata:32'h00000001, addr:32'h0000_010C,
                exp_data:32'h00000001, exp_st:8'h75};
    vecs[7] = '{op:8'h04, lat:4,  wrong:0, hold_ovr:0, rdata:32'hFFFFFFFF, addr:32'h0000_0110,
                exp_data:32'hFFFFFFFF, exp_st:8'h81};
    noops[0] = 8'h00;
    noops[1] = 8'h80;
    noops[2] = 8'h05;

    bus.exec_valid      = 1'b0;
    bus.exec_op         = 8'h00;
    bus.imem_addr       = 32'h0;
    bus.dmem_addr       = 32'h0;
    bus.cpu_imem_rdata  = 32'h0;
    bus.cpu_dmem_rdata  = 32'h0;
    bus.cpu_imem_rvalid = 1'b0;
    bus.cpu_dmem_rvalid = 1'b0;
    bus.rsp_ack         = 1'b0;

    #2 cpu_rstn = 1'b0;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    chk("reset.data",   bus.rsp_data, 32'h0);
    chk("reset.status", {24'b0, bus.rsp_status}, 32'h0);
    chk("reset.toggle", {31'b0, bus.rsp_toggle}, 32'h0);
    chk("reset.re",     {30'b0, bus.cpu_imem_re, bus.cpu_dmem_re}, 32'h0);
    cpu_rstn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // non-read opcodes in IDLE must do nothing
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      ic0  = ire_cnt;
      dc0  = dre_cnt;
      tog0 = bus.rsp_toggle;
      bus.exec_op    = noops[i];
      bus.exec_valid = 1'b1;
      @(negedge cpu_clk);
      bus.exec_valid = 1'b0;
      repeat (20) @(negedge cpu_clk);
      chk($sformatf("noop%0d.re", i), 32'((ire_cnt - ic0) + (dre_cnt - dc0)), 32'd0);
      chk($sformatf("noop%0d.toggle", i), {31'b0, bus.rsp_toggle}, {31'b0, tog0});
    end

    // reset pulsed during WAIT abandons the read
    @(negedge cpu_clk);
    bus.exec_op    = 8'h04;
    bus.exec_valid = 1'b1;
    @(negedge cpu_clk);
    bus.exec_valid = 1'b0;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rstn = 1'b0;
    #1;
    chk("rstwait.data",   bus.rsp_data, 32'h0);
    chk("rstwait.status", {24'b0, bus.rsp_status}, 32'h0);
    chk("rstwait.toggle", {31'b0, bus.rsp_toggle}, 32'h0);
    chk("rstwait.re",     {30'b0, bus.cpu_imem_re, bus.cpu_dmem_re}, 32'h0);
    bus.rsp_ack = 1'b0;
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    ic0 = ire_cnt;
    @(negedge cpu_clk);
    bus.cpu_imem_rdata  = 32'h5555AAAA;
    bus.cpu_imem_rvalid = 1'b1;
    @(negedge cpu_clk);
    bus.cpu_imem_rvalid = 1'b0;
    repeat (20) @(negedge cpu_clk);
    chk("rstwait.late_toggle", {31'b0, bus.rsp_toggle}, 32'h0);
    chk("rstwait.late_data",   bus.rsp_data, 32'h0);
    chk("rstwait.late_re",     32'(ire_cnt - ic0), 32'd0);

    // 17 back-to-back acked reads: sequence wraps to 1, toggle alternates
    for (int i = 0; i < 17; i++) begin
      w = '{op:8'h04, lat:1, wrong:0, hold_ovr:0, rdata:32'h1000_0000 + 32'(i),
            addr:32'h0000_0400 + 32'(i * 4), exp_data:32'h1000_0000 + 32'(i),
            exp_st:{4'(i + 1), 4'h1}};
      run_vec(w, $sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d.toggle", i), {31'b0, bus.rsp_toggle}, 32'((i + 1) % 2));
    end
    chk("wrap.final_seq", {28'b0, bus.rsp_status[7:4]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_readback.md
DEBUG_READBACK -- requirements
Module: debug_readback

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum cycles to wait for memory read data (range 2..255).
REQ-002 Parameter OP_READIMEM, default 8'h04, SHALL be the opcode that triggers an instruction-memory read.
REQ-003 Parameter OP_READDMEM, default 8'h06, SHALL be the opcode that triggers a data-memory read.
REQ-004 cpu_clk  input  1  sole clock; all logic rises on posedge.
REQ-005 cpu_rstn  input  1  asynchronous, active-low reset.
REQ-006 exec_valid  input  1  single-cycle pulse qualifying exec_op (already synchronised to cpu_clk).
REQ-007 exec_op  input  8  debug opcode.
REQ-008 imem_addr / dmem_addr  input  32 each  stored debug read addresses.
REQ-009 cpu_imem_re / cpu_dmem_re  output  1 each  one-cycle read strobes.
REQ-010 cpu_imem_rdata / cpu_dmem_rdata  input  32 each  read data.
REQ-011 cpu_imem_rvalid / cpu_dmem_rvalid  input  1 each  read data valid.
REQ-012 rsp_data  output  32  captured read word presented to the TAP capture register.
REQ-013 rsp_status  output  8  [0] valid, [1] timeout, [2] overrun, [3] imem(0)/dmem(1), [7:4] sequence count.
REQ-014 rsp_toggle  output  1  flips once per published response.
REQ-015 rsp_ack  input  1  TAP acknowledge level (already synchronised); equals rsp_toggle once the TAP has consumed the response.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, PUBLISH, HOLD.
REQ-017 IDLE: exec_valid with OP_READIMEM or OP_READDMEM SHALL latch the memory select and go to REQ; all other opcodes are ignored.
REQ-018 REQ: assert the selected re for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-019 WAIT: the selected rvalid SHALL capture rdata into rsp_data with status valid=1, timeout=0, then go to PUBLISH; the rvalid of the unselected memory is ignored.
REQ-020 WAIT: when the counter reaches TIMEOUT_CYCLES without rvalid, rsp_data SHALL be 32'hDEADBEEF, valid=0, timeout=1, then go to PUBLISH.
REQ-021 rvalid on the same cycle as timeout expiry SHALL count as success.
REQ-022 PUBLISH: flip rsp_toggle, increment the sequence count (4-bit, wraps 15->0), go to HOLD; rsp_data/rsp_status SHALL be stable from this cycle until the next PUBLISH.
REQ-023 HOLD: remain until rsp_ack == rsp_toggle, then go to IDLE.
REQ-024 Read latency: re is asserted the cycle after exec_valid, and rsp_toggle flips the cycle after rvalid is sampled.
REQ-025 exec_valid with a read opcode in any state other than IDLE SHALL set overrun=1 (sticky until the next PUBLISH of a new request) and be dropped without issuing a read.
REQ-026 The overrun bit SHALL appear in the status published for the next accepted request, then clear.
REQ-027 Address SHALL be forwarded combinationally from imem_addr/dmem_addr. Stability is the controller's duty while busy.

Reset
REQ-028 On cpu_rstn low, asynchronously: FSM=IDLE, re strobes=0, rsp_data=0, rsp_status=0, rsp_toggle=0, counters=0.
REQ-029 Reset mid-WAIT or mid-HOLD SHALL abandon the request with no publish; the TAP side is expected to reset its ack with it.

Structure
REQ-030 Opcode values, status bit indices and the timeout sentinel SHALL live in a shared debug_pkg used by debug_readback and the existing debug controller.
REQ-031 One sub-module, readback_timer (loadable down-counter with expiry flag), is natural; everything else SHALL stay flat.

Verification
REQ-032 exec READIMEM, imem_addr=0x100, rvalid 3 cycles after re with rdata=0x12345678 -> rsp_data=0x12345678, status=0x11, rsp_toggle=1.
REQ-033 exec READDMEM, rvalid never asserted, TIMEOUT_CYCLES=16 -> publish 16 cycles after WAIT entry, rsp_data=0xDEADBEEF, status[1]=1, status[3]=1.
REQ-034 Second READDMEM while in HOLD -> no dmem_re, and after ack plus the next accepted read, status[2]=1 in that response.
REQ-035 17 consecutive acked reads -> sequence count wraps to 1, and rsp_toggle alternates every response.
REQ-036 cpu_rstn pulsed low during WAIT -> all outputs 0 immediately, and a later rvalid produces no publish.
REQ-037 exec NOOP/0x80/0x05 in IDLE -> no re strobe and no toggle change.
